stopwatch_controller: RTL and testbench
=======================================

# stopwatch_controller

Sequencing controller for the stopwatch's minutes counter. Converts start/stop/clear button levels into a three-state run/pause/idle FSM. Divides the system clock into a one-second tick and maintains a 0–59 seconds count. Drives the one-cycle `enable` and `clear` strobes that the minutes counter consumes.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: clock cycles per second; must be ≥ 2. Prescaler width is $clog2(TICKS_PER_SEC).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: start/resume button level; acts on its rising edge.
- `stop` in 1: pause button level; acts on its rising edge.
- `clear` in 1: clear button level; acts on its rising edge.
- `seconds` out 6: current seconds value, 0–59.
- `min_enable` out 1: one-cycle increment strobe to the minutes counter.
- `min_clear` out 1: one-cycle clear strobe to the minutes counter.
- `running` out 1: high while in RUNNING.
- `state` out 2: FSM state encoding; IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10.

## Operation
- **Edge detect.** One register per button holds the previous level; reset value is 0. A rise is `level & ~prev`. A button already high when reset releases counts as a rise on the first cycle after reset.
- **Same-cycle priority.** When several rises occur in one cycle: clear > stop > start. Only the highest-priority rise acts; the others are dropped.
- **IDLE**
  - start rise → RUNNING; prescaler and seconds begin at 0.
  - clear rise → stay IDLE and pulse `min_clear`.
  - stop rise → ignored.
- **RUNNING**
  - stop rise → PAUSED.
  - clear rise → IDLE.
  - start rise → ignored.
- **PAUSED**
  - start rise → RUNNING; prescaler and seconds resume from their held values.
  - clear rise → IDLE.
  - stop rise → ignored.
- **Clear action (any state).** Prescaler ← 0 and seconds ← 0. `min_clear` is asserted in the following cycle.
- **Prescaler.** Advances only in a cycle that starts and stays in RUNNING with no clear or stop rise.
  - Counts 0 … TICKS_PER_SEC-1, then wraps to 0.
  - The wrap cycle is the tick.
- **Seconds.**
  - On a tick: seconds +1.
  - At 59 + tick: seconds → 0, and `min_enable` is asserted.
- **Suppressed events.** A clear or stop rise in a terminal-count cycle suppresses that tick.
  - With stop, the prescaler holds at TICKS_PER_SEC-1. The tick fires on the first RUNNING cycle after resume.
  - With clear, no `min_enable` is produced.
- No arithmetic overflow is possible: seconds never exceeds 59, and the prescaler never exceeds TICKS_PER_SEC-1.

## Timing
- **Reset values:**
  - `state` = IDLE
  - `running` = 0
  - `seconds` = 0
  - `min_enable` = 0
  - `min_clear` = 0
  - prescaler = 0
  - edge registers = 0
- Every output is registered; there are no combinational input-to-output paths.
- **Button to state.** A button rise sampled at edge N makes `state`/`running` change after edge N. The change is visible in cycle N+1.
- **Run timing.** Let edge 0 be the edge that enters RUNNING.
  - The first tick occurs at edge TICKS_PER_SEC, when `seconds` becomes 1.
  - The 60th tick occurs at edge 60·TICKS_PER_SEC.
- **Strobes.** `min_enable` and `min_clear` are each high for exactly one cycle.
  - `min_enable` is high in the same cycle `seconds` first reads 0 after a rollover.
  - `min_clear` is high in the cycle after the clear rise is sampled.
  - The minutes counter updates on the edge that ends that strobe cycle.
  - `min_enable` and `min_clear` are never high together.
- **Reset mid-operation.** `rst` high on any edge forces the reset values on that edge, overriding every button and any pending tick.
- **Held buttons.** A level held high produces exactly one action; a new action requires a low-then-high transition.

## Test plan
1. Assert `rst` for 2 cycles mid-run with `seconds`=17 → after the reset edge: `seconds`=0, `state`=00, both strobes 0; no `min_enable` for the interrupted minute.
2. Set `TICKS_PER_SEC`=4. Start rise, then run 240 cycles → `seconds` steps 0..59 every 4 cycles. At cycle 240, `seconds`=0 and `min_enable`=1 for exactly one cycle.
3. Set `TICKS_PER_SEC`=4. Start, then stop rise at cycle 10 (seconds=2, prescaler=2) and hold 50 cycles → values frozen, `state`=10. Start rise → `seconds`=3 after 2 RUNNING cycles.
4. While RUNNING with `seconds`=30, clear rise → next cycle `min_clear`=1 and `seconds`=0; `state`=00 one cycle after the rise.
5. Clear rise coincident with seconds=59 at terminal count → `min_clear` pulses and `seconds`=0; `min_enable` stays 0 throughout.
6. In RUNNING, stop and start rise on the same cycle → `state`=PAUSED. Then hold `start` high for 20 cycles → one transition to RUNNING only.

Source files
------------

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - run/pause/idle sequencer, seconds prescaler and minutes-counter strobes
module stopwatch_controller #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [5:0] seconds,
  output logic       min_enable,
  output logic       min_clear,
  output logic       running,
  output logic [1:0] state
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic start_prev;
  logic stop_prev;
  logic clear_prev;

  logic start_rise;
  logic stop_rise;
  logic clear_rise;

  // Priority-resolved actions: clear beats stop beats start.
  logic clear_act;
  logic stop_act;
  logic start_act;

  logic [PW-1:0] presc;
  logic          advance;
  logic          tick;

  assign start_rise = start & ~start_prev;
  assign stop_rise  = stop  & ~stop_prev;
  assign clear_rise = clear & ~clear_prev;

  assign clear_act = clear_rise;
  assign stop_act  = stop_rise  & ~clear_rise;
  assign start_act = start_rise & ~clear_rise & ~stop_rise;

  // A cycle advances only if it begins in RUNNING and nothing will take it out.
  assign advance = (state_q == RUNNING) & ~clear_rise & ~stop_rise;
  assign tick    = advance & (presc == PRESC_LAST);

  // Previous button levels for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      clear_prev <= 1'b0;
    end else begin
      start_prev <= start;
      stop_prev  <= stop;
      clear_prev <= clear;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear_act) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_act) state_d = RUNNING;
        RUNNING: if (stop_act)  state_d = PAUSED;
        PAUSED:  if (start_act) state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the registered state only.
  always_comb begin
    state   = state_q;
    running = (state_q == RUNNING);
  end

  // Prescaler, seconds count and the registered minutes-counter strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      seconds    <= 6'd0;
      min_enable <= 1'b0;
      min_clear  <= 1'b0;
    end else begin
      min_clear  <= clear_act;
      min_enable <= tick & (seconds == 6'd59);
      if (clear_act || (start_act && state_q == IDLE)) begin
        presc   <= '0;
        seconds <= 6'd0;
      end else if (advance) begin
        if (tick) begin
          presc   <= '0;
          seconds <= (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - vector table, corner sequences and random run against a reference model
module tb_stopwatch_controller;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] seconds;
  logic       min_enable;
  logic       min_clear;
  logic       running;
  logic [1:0] state;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: run_cycles counts advancing cycles since the last clear.
  int   m_state = 0;
  int   m_run = 0;
  logic m_ps = 1'b0;
  logic m_pp = 1'b0;
  logic m_pc = 1'b0;
  logic m_en = 1'b0;
  logic m_cl = 1'b0;

  typedef struct {
    logic       r;
    logic       s;
    logic       p;
    logic       c;
    logic [1:0] st;
    logic [5:0] sec;
    logic       en;
    logic       cl;
  } vec_t;

  vec_t tbl[15];

  stopwatch_controller #(.TICKS_PER_SEC(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .seconds    (seconds),
    .min_enable (min_enable),
    .min_clear  (min_clear),
    .running    (running),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic s, input logic p, input logic c);
    logic cr, pr, sr, adv;
    if (r) begin
      m_state = 0; m_run = 0; m_ps = 0; m_pp = 0; m_pc = 0; m_en = 0; m_cl = 0;
    end else begin
      cr  = c & ~m_pc;
      pr  = p & ~m_pp;
      sr  = s & ~m_ps;
      adv = (m_state == 1) && !cr && !pr;
      m_en = 1'b0;
      m_cl = cr;
      if (cr) begin
        m_state = 0;
        m_run   = 0;
      end else if (pr) begin
        if (m_state == 1) m_state = 2;
      end else if (sr) begin
        if (m_state == 0) begin
          m_state = 1;
          m_run   = 0;
        end else if (m_state == 2) begin
          m_state = 1;
        end
      end
      if (adv) begin
        m_run++;
        m_en = (m_run % (60 * T)) == 0;
      end
      m_ps = s; m_pp = p; m_pc = c;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic p, input logic c);
    @(negedge clk);
    rst = r; start = s; stop = p; clear = c;
    @(posedge clk);
    model_step(r, s, p, c);
    #1;
    chk("state", state, m_state);
    chk("running", running, (m_state == 1));
    chk("seconds", seconds, (m_run / T) % 60);
    chk("min_enable", min_enable, m_en);
    chk("min_clear", min_clear, m_cl);
  endtask

  initial begin
    int en_cnt;
    int n_tr;
    logic [1:0] prev_st;
    logic rs, rp, rc;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 6'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 6'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 6'd1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 6'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 6'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 6'd0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].c);
      chk("tbl_state", state, tbl[i].st);
      chk("tbl_seconds", seconds, tbl[i].sec);
      chk("tbl_min_enable", min_enable, tbl[i].en);
      chk("tbl_min_clear", min_clear, tbl[i].cl);
    end

    // Reset mid-run at seconds=17.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (68) cyc(0, 0, 0, 0);
    chk("rst_pre_seconds", seconds, 17);
    cyc(1, 0, 0, 0);
    chk("rst_seconds", seconds, 0);
    chk("rst_state", state, 0);
    chk("rst_min_enable", min_enable, 0);
    chk("rst_min_clear", min_clear, 0);
    cyc(1, 0, 0, 0);
    en_cnt = 0;
    repeat (250) begin
      cyc(0, 0, 0, 0);
      if (min_enable) en_cnt++;
    end
    chk("rst_no_min_enable", en_cnt, 0);

    // Full minute.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    en_cnt = 0;
    for (int k = 1; k <= 240; k++) begin
      cyc(0, 0, 0, 0);
      if (min_enable) en_cnt++;
      if (k % 4 == 0) chk("min_seconds", seconds, (k / 4) % 60);
      if (k == 240) chk("min_enable_at_240", min_enable, 1);
    end
    cyc(0, 0, 0, 0);
    chk("min_enable_one_cycle", min_enable, 0);
    chk("min_enable_count", en_cnt, 1);

    // Stop at terminal count suppresses the tick until resume.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("stop_tc_state", state, 2);
    chk("stop_tc_seconds", seconds, 0);
    repeat (10) cyc(0, 0, 1, 0);
    chk("stop_held_seconds", seconds, 0);
    cyc(0, 1, 0, 0);
    chk("resume_state", state, 1);
    chk("resume_seconds", seconds, 0);
    cyc(0, 0, 0, 0);
    chk("resume_tick", seconds, 1);

    // Clear coincident with seconds=59 at terminal count.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (239) cyc(0, 0, 0, 0);
    chk("clr59_pre_seconds", seconds, 59);
    cyc(0, 0, 0, 1);
    chk("clr59_min_clear", min_clear, 1);
    chk("clr59_seconds", seconds, 0);
    chk("clr59_state", state, 0);
    en_cnt = min_enable ? 1 : 0;
    repeat (10) begin
      cyc(0, 0, 0, 0);
      if (min_enable) en_cnt++;
    end
    chk("clr59_no_min_enable", en_cnt, 0);

    // Stop and start rising together, then a held start.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    chk("stop_start_state", state, 2);
    cyc(0, 0, 0, 0);
    n_tr = 0;
    for (int k = 0; k < 20; k++) begin
      prev_st = state;
      cyc(0, 1, 0, 0);
      if (prev_st != 2'd1 && state == 2'd1) n_tr++;
    end
    chk("held_start_transitions", n_tr, 1);
    chk("held_start_state", state, 1);

    // Random button activity against the model.
    cyc(1, 0, 0, 0);
    rs = 0; rp = 0; rc = 0;
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) rs = ~rs;
      if ($urandom_range(0, 9) == 0) rp = ~rp;
      if ($urandom_range(0, 39) == 0) rc = ~rc;
      cyc(($urandom_range(0, 299) == 0), rs, rp, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
